// File: rtl/fetch_pc_controller.sv
// Fetch PC controller: owns the IF-stage PC and picks the next fetch address
// from EX redirect, ID jump, BTB prediction or sequential PC+4, in that order.
// A jump resolved while IF cannot advance is parked in pending_pc (HOLD state)
// and loaded as soon as fetch can move again, unless an EX redirect wins first.
module fetch_pc_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_redirect_pc,
  input  logic             id_jump_en,
  input  logic [31:0]      id_jump_pc,
  input  logic             btb_valid,
  input  logic             btb_taken,
  input  logic [31:0]      btb_target,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [1:0]       pc_sel,
  output logic             pc_we,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BTB  = 2'b01;
  localparam logic [1:0] SEL_JUMP = 2'b10;
  localparam logic [1:0] SEL_EX   = 2'b11;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pending_pc;
  logic [31:0] pending_next;
  logic [31:0] pc_next;
  logic        cnt_inc;
  logic        advance;

  // Fetch can only move forward when memory accepts and the hazard unit allows it.
  assign advance   = imem_ready & ~stall;
  assign imem_addr = pc;

  // Next-PC selection, flushes and state transitions.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_pc;
    pc_sel       = SEL_SEQ;
    pc_we        = 1'b0;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    cnt_inc      = 1'b0;
    imem_req     = 1'b0;
    case (state)
      ST_BOOT: begin
        // First cycle out of reset: no fetch, redirects and jumps ignored.
        state_next = ST_RUN;
      end
      ST_RUN: begin
        imem_req = 1'b1;
        if (ex_redirect) begin
          // Mispredict wins over everything, even a stall.
          pc_next  = ex_redirect_pc;
          pc_sel   = SEL_EX;
          pc_we    = 1'b1;
          flush_if = 1'b1;
          flush_id = 1'b1;
          cnt_inc  = 1'b1;
        end else if (id_jump_en && advance) begin
          pc_next  = id_jump_pc;
          pc_sel   = SEL_JUMP;
          pc_we    = 1'b1;
          flush_if = 1'b1;
        end else if (id_jump_en) begin
          // Cannot take the jump now; remember it and stop fetching.
          pending_next = id_jump_pc;
          state_next   = ST_HOLD;
          flush_if     = 1'b1;
        end else if (advance && btb_valid && btb_taken) begin
          pc_next = btb_target;
          pc_sel  = SEL_BTB;
          pc_we   = 1'b1;
        end else if (advance) begin
          pc_next = pc + 32'd4;
          pc_sel  = SEL_SEQ;
          pc_we   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ex_redirect) begin
          // Older mispredict supersedes the parked jump target.
          pc_next    = ex_redirect_pc;
          pc_sel     = SEL_EX;
          pc_we      = 1'b1;
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          cnt_inc    = 1'b1;
          state_next = ST_RUN;
        end else if (advance) begin
          pc_next    = pending_pc;
          pc_sel     = SEL_JUMP;
          pc_we      = 1'b1;
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // Architectural PC, FSM state and parked jump target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      pending_pc <= 32'h0000_0000;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pending_pc <= pending_next;
    end
  end

  // Saturating count of accepted EX redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
    end else if (cnt_inc && (redirect_cnt != {CNT_W{1'b1}})) begin
      redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Scoreboard bench for fetch_pc_controller: the driver issues one cycle of
// stimulus, predicts the DUT's outputs for that cycle with a reference model
// and queues the prediction; an independent monitor pops and compares.
module tb_fetch_pc_controller;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          CW     = 4;
  localparam int          SAT    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, imem_ready, ex_redirect, id_jump_en, btb_valid, btb_taken;
  logic [31:0]   ex_redirect_pc, id_jump_pc, btb_target;
  logic [31:0]   pc, imem_addr;
  logic          imem_req, pc_we, flush_if, flush_id;
  logic [1:0]    pc_sel;
  logic [CW-1:0] redirect_cnt;

  fetch_pc_controller #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .id_jump_en(id_jump_en), .id_jump_pc(id_jump_pc),
    .btb_valid(btb_valid), .btb_taken(btb_taken), .btb_target(btb_target),
    .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .pc_sel(pc_sel),
    .pc_we(pc_we), .flush_if(flush_if), .flush_id(flush_id),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        req;
    logic [1:0]  sel;
    logic        we;
    logic        fi;
    logic        fd;
    int          cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;

  // Reference model: "booting" = first cycle after reset, "have_pending" =
  // a jump target is parked and fetch is suspended.
  logic        m_booting, m_have_pending;
  logic [31:0] m_pc, m_pending;
  int          m_cnt;
  logic        n_booting, n_have_pending;
  logic [31:0] n_pc, n_pending;
  int          n_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_booting      = 1'b1;
    m_have_pending = 1'b0;
    m_pc           = RST_PC;
    m_pending      = 32'h0;
    m_cnt          = 0;
  endtask

  task automatic step(input logic r, input logic s, input logic rdy,
                      input logic exr, input logic [31:0] exr_pc,
                      input logic jmp, input logic [31:0] jmp_pc,
                      input logic bv, input logic bt, input logic [31:0] btgt);
    exp_t e;
    logic adv;
    @(negedge clk);
    rst_n = r; stall = s; imem_ready = rdy;
    ex_redirect = exr; ex_redirect_pc = exr_pc;
    id_jump_en = jmp; id_jump_pc = jmp_pc;
    btb_valid = bv; btb_taken = bt; btb_target = btgt;
    if (!r) model_reset();
    adv = rdy && !s;
    e.id = txn++; e.pc = m_pc; e.cnt = m_cnt;
    e.req = 1'b0; e.sel = 2'd0; e.we = 1'b0; e.fi = 1'b0; e.fd = 1'b0;
    n_booting = m_booting; n_have_pending = m_have_pending;
    n_pc = m_pc; n_pending = m_pending; n_cnt = m_cnt;
    if (!r) begin
      // held in reset: nothing moves
    end else if (m_booting) begin
      n_booting = 1'b0;
    end else if (exr) begin
      e.req = !m_have_pending;
      e.sel = 2'd3; e.we = 1'b1; e.fi = 1'b1; e.fd = 1'b1;
      n_pc = exr_pc; n_have_pending = 1'b0;
      n_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
    end else if (m_have_pending) begin
      if (adv) begin
        e.sel = 2'd2; e.we = 1'b1;
        n_pc = m_pending; n_have_pending = 1'b0;
      end
    end else begin
      e.req = 1'b1;
      if (jmp && adv) begin
        e.sel = 2'd2; e.we = 1'b1; e.fi = 1'b1; n_pc = jmp_pc;
      end else if (jmp) begin
        e.fi = 1'b1; n_pending = jmp_pc; n_have_pending = 1'b1;
      end else if (adv && bv && bt) begin
        e.sel = 2'd1; e.we = 1'b1; n_pc = btgt;
      end else if (adv) begin
        e.sel = 2'd0; e.we = 1'b1; n_pc = m_pc + 32'd4;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    m_booting = n_booting; m_have_pending = n_have_pending;
    m_pc = n_pc; m_pending = n_pending; m_cnt = n_cnt;
  endtask

  task automatic run_step();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic redirect_step(input logic [31:0] t);
    step(1'b1, 1'b0, 1'b1, 1'b1, t, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: compares every presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc", pc, e.pc);
        check("imem_addr", imem_addr, e.pc);
        check("imem_req", {31'h0, imem_req}, {31'h0, e.req});
        check("pc_sel", {30'h0, pc_sel}, {30'h0, e.sel});
        check("pc_we", {31'h0, pc_we}, {31'h0, e.we});
        check("flush_if", {31'h0, flush_if}, {31'h0, e.fi});
        check("flush_id", {31'h0, flush_id}, {31'h0, e.fd});
        check("redirect_cnt", {{(32-CW){1'b0}}, redirect_cnt}, e.cnt);
        $display("[TB] txn %0d pc=%08h req=%0b sel=%0d we=%0b fl=%0b%0b cnt=%0d",
                 e.id, pc, imem_req, pc_sel, pc_we, flush_if, flush_id, redirect_cnt);
      end
    end
  end

  initial begin
    int wait_cyc;
    rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b0; ex_redirect = 1'b0;
    ex_redirect_pc = 32'h0; id_jump_en = 1'b0; id_jump_pc = 32'h0;
    btb_valid = 1'b0; btb_taken = 1'b0; btb_target = 32'h0;
    model_reset();

    // Reset, boot cycle, then sequential fetch 0x0, 0x4, 0x8.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    repeat (4) run_step();

    // BTB taken vs not taken from 0x100.
    redirect_step(32'h100);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    redirect_step(32'h100);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200);
    run_step();

    // Redirect beats jump and BTB even while stalled.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 1'b1, 32'h200);
    run_step();

    // Jump while stalled parks 0x300; released once stall drops.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1, 1'b1, 32'h900);
    run_step();
    run_step();

    // Redirect in HOLD discards the parked target.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) run_step();

    // PC wraps modulo 2^32.
    redirect_step(32'hFFFF_FFFC);
    run_step();
    run_step();

    // Counter saturation.
    repeat ((1 << CW) + 3) redirect_step($urandom & 32'hFFFF_FFFC);
    run_step();

    // Asynchronous reset in the middle of HOLD.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_pc", pc, RST_PC);
    check("async_reset_req", {31'h0, imem_req}, 32'h0);
    check("async_reset_cnt", {{(32-CW){1'b0}}, redirect_cnt}, 32'h0);
    model_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) run_step();

    // Randomized traffic.
    repeat (600) begin
      step(1'b1, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 9) < 2), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC);
    end

    // Let the monitor drain, bounded.
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #5;
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_controller.md
Name: fetch_pc_controller

Overview:
- Owns the architectural fetch PC register and sequences next-PC selection for the IF stage.
- Sources, in priority order: EX mispredict redirect, ID jump, BTB taken prediction, sequential PC+4.
- Handles stall and instruction-memory backpressure, holds a deferred jump target while stalled, and drives flush requests and a saturating redirect counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard-unit stall of IF.
- imem_ready  in  1  instruction memory can accept a request this cycle.
- ex_redirect  in  1  EX-stage branch mispredict; load ex_redirect_pc.
- ex_redirect_pc  in  32  corrected target.
- id_jump_en  in  1  ID-stage jump resolved.
- id_jump_pc  in  32  jump target.
- btb_valid  in  1  BTB hit for the current pc.
- btb_taken  in  1  BTB predicts taken.
- btb_target  in  32  predicted target.
- pc  out  32  current fetch PC (registered).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  equals pc.
- pc_sel  out  2  source loaded this cycle: 00 PC+4, 01 BTB, 10 jump/pending, 11 EX redirect. 00 when pc does not update.
- pc_we  out  1  pc updates at the next edge.
- flush_if  out  1  kill the IF/ID instruction.
- flush_id  out  1  kill the ID/EX instruction.
- redirect_cnt  out  CNT_W  count of EX redirects, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT, pending cleared, redirect_cnt=0.
  - All 1-bit outputs 0; pc_sel=00.
- States:
  - BOOT: one cycle; imem_req=0; pc held; goes to RUN unconditionally.
  - RUN: imem_req=1.
  - HOLD: jump target pending; imem_req=0.
- advance = imem_ready & ~stall.
- RUN next-PC (priority):
  - ex_redirect: pc<=ex_redirect_pc regardless of advance; pc_sel=11; flush_if=flush_id=1.
  - else id_jump_en & advance: pc<=id_jump_pc; pc_sel=10; flush_if=1.
  - else id_jump_en & ~advance: pending_pc<=id_jump_pc; go to HOLD; pc held; flush_if=1.
  - else advance & btb_valid & btb_taken: pc<=btb_target; pc_sel=01.
  - else advance: pc<=pc+4, wrapping modulo 2^32; pc_sel=00.
  - else: hold.
- HOLD:
  - ex_redirect: pc<=ex_redirect_pc; pending discarded; go to RUN; flushes as above.
  - else advance: pc<=pending_pc; pc_sel=10; go to RUN.
  - else: stay.
  - BTB and id_jump_en are ignored in HOLD.
- BOOT: ex_redirect and id_jump_en are ignored.
- pc_we=1 exactly when pc changes source-selected value at the next edge.
- pc_sel, pc_we, flush_if and flush_id are combinational from state and inputs.
- redirect_cnt increments on every accepted ex_redirect and saturates at all-ones.
- imem_addr=pc at all times. A new fetch is presented one cycle after pc_we.
- Reset asserted mid-HOLD discards the pending target immediately.

Test Plan:
- Release reset, imem_ready=1, stall=0 -> BOOT 1 cycle with imem_req=0, then pc=0x0,0x4,0x8, pc_sel=00.
- pc=0x100, btb_valid=btb_taken=1, btb_target=0x200 -> next pc=0x200, pc_sel=01. Same case with btb_taken=0 -> pc=0x104.
- ex_redirect=1 (target 0x400), id_jump_en=1 and btb taken in the same cycle with stall=1 -> pc=0x400, pc_sel=11, flush_if=flush_id=1, redirect_cnt+1.
- id_jump_en=1 (0x300) while stall=1 -> HOLD, imem_req=0, pc unchanged for 3 stalled cycles. Stall drops -> pc=0x300, pc_sel=10, state RUN.
- In HOLD with pending 0x300, ex_redirect to 0x500 -> pc=0x500, pending discarded, no later load of 0x300.
- pc=0xFFFF_FFFC advancing -> pc=0x0. 2^CNT_W+3 redirects -> redirect_cnt stays at all-ones.
- Assert rst_n=0 mid-HOLD -> pc=RESET_PC immediately, state=BOOT.
